// File: rtl/parking_keypad_entry.sv
// parking_keypad_entry
//   Driver-side keypad front end for the car park entry gate. While a car is at
//   the entry, bit keys are shifted into a CODE_W-bit code (first key lands in
//   the MSB). Enter on a complete code presents it on password_input, with
//   code_valid held high for HOLD_CYCLES cycles so the gate controller samples
//   a stable value. Clear, inter-key timeout, malformed entry and the car
//   leaving are also handled here. All outputs are registered.
//
//   Ports
//     clk             in   1       system clock, rising edge
//     reset           in   1       asynchronous, active-high
//     car_present     in   1       entry sensor level; arms the keypad
//     key_valid       in   1       one-cycle strobe per key press
//     key_code        in   4       0x0/0x1 bit key, 0xC Clear, 0xE Enter
//     password_input  out  CODE_W  code presented to the gate controller
//     code_valid      out  1       high while password_input carries a code
//     entry_error     out  1       one-cycle pulse on a rejected entry
//     digits_entered  out  3       bits collected so far
//
//   state   | meaning
//   IDLE    | no car, or just left PRESENT/timed out; keys ignored
//   COLLECT | car at entry, assembling the code
//   PRESENT | code driven with code_valid for HOLD_CYCLES cycles

module parking_keypad_entry #(
   parameter int unsigned CODE_W         = 4,
   parameter int unsigned HOLD_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned BLANK_CODE     = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              car_present,
   input  logic              key_valid,
   input  logic [3:0]        key_code,
   output logic [CODE_W-1:0] password_input,
   output logic              code_valid,
   output logic              entry_error,
   output logic [2:0]        digits_entered
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_t;

   localparam logic [2:0]        COUNT_FULL   = 3'(CODE_W);
   localparam logic [7:0]        HOLD_LOAD    = 8'(HOLD_CYCLES);
   localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [CODE_W-1:0] BLANK        = CODE_W'(BLANK_CODE);

   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_ENTER = 4'hE;

   state_t              state_q, state_d;
   logic [CODE_W-1:0]   sreg_q, sreg_d;
   logic [2:0]          count_q, count_d;
   logic [15:0]         timer_q, timer_d;
   logic [7:0]          hold_q, hold_d;
   logic [CODE_W-1:0]   pw_q, pw_d;
   logic                cv_q, cv_d;
   logic                err_q, err_d;
   logic                bit_key;

   assign bit_key = (key_code[3:1] == 3'b000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         count_q <= '0;
         timer_q <= '0;
         hold_q  <= '0;
         pw_q    <= BLANK;
         cv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         count_q <= count_d;
         timer_q <= timer_d;
         hold_q  <= hold_d;
         pw_q    <= pw_d;
         cv_q    <= cv_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      count_d = count_q;
      timer_d = timer_q;
      hold_d  = hold_q;
      pw_d    = pw_q;
      cv_d    = cv_q;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            pw_d    = BLANK;
            cv_d    = 1'b0;
            count_d = '0;
            if (car_present) begin
               state_d = COLLECT;
               sreg_d  = '0;
               timer_d = '0;
            end
         end

         COLLECT: begin
            if (!car_present) begin
               state_d = IDLE;
               count_d = '0;
               sreg_d  = '0;
               timer_d = '0;
            end else if (key_valid) begin
               timer_d = '0;
               if (bit_key) begin
                  if (count_q < COUNT_FULL) begin
                     sreg_d  = {sreg_q[CODE_W-2:0], key_code[0]};
                     count_d = count_q + 3'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  count_d = '0;
                  sreg_d  = '0;
               end else if (key_code == KEY_ENTER) begin
                  if (count_q == COUNT_FULL) begin
                     state_d = PRESENT;
                     pw_d    = sreg_q;
                     cv_d    = 1'b1;
                     hold_d  = HOLD_LOAD;
                  end else begin
                     err_d   = 1'b1;
                     count_d = '0;
                     sreg_d  = '0;
                  end
               end
            end else if (timer_q == TIMEOUT_LAST) begin
               // This idle cycle brings the timer to TIMEOUT_CYCLES.
               err_d   = 1'b1;
               count_d = '0;
               sreg_d  = '0;
               timer_d = '0;
               state_d = IDLE;
            end else if (timer_q != 16'hFFFF) begin
               timer_d = timer_q + 16'd1;
            end
         end

         PRESENT: begin
            // hold_q counts the remaining valid cycles including the current one.
            if (hold_q <= 8'd1) begin
               state_d = IDLE;
               pw_d    = BLANK;
               cv_d    = 1'b0;
               count_d = '0;
               hold_d  = '0;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign password_input = pw_q;
   assign code_valid     = cv_q;
   assign entry_error    = err_q;
   assign digits_entered = count_q;

endmodule
